// File: rtl/sipo_deframer_pkg.sv
// Shared types and constants for the serial-in deframer.
// Frame: start(1), data LSB first, optional parity, stop(0).
package sipo_deframer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic START_BIT  = 1'b1;
  localparam logic STOP_BIT   = 1'b0;
  localparam int   DATA_W_DEF = 8;

endpackage

// File: rtl/deframer_obuf.sv
// One-entry output holding register with valid/ready handshake.
// A word arriving while the entry is full and not draining is dropped.
module deframer_obuf
  import sipo_deframer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] din,
  input  logic              dout_ready,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              overrun
);

  logic [DATA_W-1:0] dout_q, dout_d;
  logic              valid_q, valid_d;
  logic              ovr_q, ovr_d;
  logic              hs;

  assign hs = valid_q && dout_ready;

  always_comb begin
    dout_d  = dout_q;
    valid_d = valid_q;
    ovr_d   = 1'b0;
    if (load) begin
      if (!valid_q || hs) begin
        dout_d  = din;
        valid_d = 1'b1;
      end else begin
        ovr_d   = 1'b1;
      end
    end else if (hs) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      dout_q  <= dout_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign overrun    = ovr_q;

endmodule

// File: rtl/sipo_deframer.sv
// Serial-to-parallel deframer: FSM + shifter feeding deframer_obuf.
// Even-parity bit enabled by defining SIPO_DEFRAMER_PARITY_EN.
module sipo_deframer
  import sipo_deframer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              si,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              frame_err,
  output logic              par_err,
  output logic              overrun
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              ferr_q, ferr_d;
  logic              perr_d;
  logic              load;
`ifdef SIPO_DEFRAMER_PARITY_EN
  logic              pbit_q, pbit_d;
  logic              perr_q;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    ferr_d  = 1'b0;
    perr_d  = 1'b0;
    load    = 1'b0;
`ifdef SIPO_DEFRAMER_PARITY_EN
    pbit_d  = pbit_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (si == START_BIT) begin
          state_d = DATA;
          cnt_d   = '0;
        end
      end
      DATA: begin
        shreg_d[cnt_q] = si;
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
          cnt_d = '0;
`ifdef SIPO_DEFRAMER_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PARITY: begin
`ifdef SIPO_DEFRAMER_PARITY_EN
        pbit_d  = si;
        state_d = STOP;
`else
        state_d = IDLE;
`endif
      end
      STOP: begin
        // a 1 here is a framing error, never a new start bit
        state_d = IDLE;
        ferr_d  = (si != STOP_BIT);
`ifdef SIPO_DEFRAMER_PARITY_EN
        perr_d  = ^{shreg_q, pbit_q};
`endif
        load    = !ferr_d && !perr_d;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      ferr_q  <= ferr_d;
    end
  end

`ifdef SIPO_DEFRAMER_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pbit_q <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      pbit_q <= pbit_d;
      perr_q <= perr_d;
    end
  end
  assign par_err = perr_q;
`else
  assign par_err = 1'b0;
`endif

  assign frame_err = ferr_q;

  deframer_obuf #(
    .DATA_W(DATA_W)
  ) u_obuf (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .din       (shreg_d),
    .dout_ready(dout_ready),
    .dout      (dout),
    .dout_valid(dout_valid),
    .overrun   (overrun)
  );

endmodule

// File: tb/tb_sipo_deframer.sv
// Self-checking bench for sipo_deframer (DATA_W=8): frame-level model
// plus directed literal checks.
module tb_sipo_deframer;
  import sipo_deframer_pkg::*;

  localparam int W = 8;
`ifdef SIPO_DEFRAMER_PARITY_EN
  localparam int FLEN = W + 2;
  localparam bit PAR = 1'b1;
`else
  localparam int FLEN = W + 1;
  localparam bit PAR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         si = 1'b0;
  logic         dout_ready = 1'b1;
  logic [W-1:0] dout;
  logic         dout_valid;
  logic         frame_err;
  logic         par_err;
  logic         overrun;

  int n_checks = 0;
  int n_fail   = 0;

  sipo_deframer #(.DATA_W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .si        (si),
    .dout      (dout),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .frame_err (frame_err),
    .par_err   (par_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // frame-level model: collect bits after a start, judge the whole frame
  bit         busy;
  bit         bits[$];
  logic [W-1:0] m_dout;
  bit         m_valid, m_ferr, m_perr, m_ovr;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      busy = 0; bits.delete();
      m_dout = '0; m_valid = 0;
      m_ferr = 0; m_perr = 0; m_ovr = 0;
    end else begin
      bit hs, good;
      logic [W-1:0] word;
      hs = m_valid && dout_ready;
      good = 0;
      word = '0;
      m_ferr = 0; m_perr = 0; m_ovr = 0;
      if (!busy) begin
        if (si) begin
          busy = 1;
          bits.delete();
        end
      end else begin
        bits.push_back(si);
        if (bits.size() == FLEN) begin
          int ones;
          busy = 0;
          ones = 0;
          for (int i = 0; i < W; i++) begin
            word[i] = bits[i];
            ones += int'(bits[i]);
          end
          if (PAR) ones += int'(bits[W]);
          m_ferr = bits[FLEN-1];
          m_perr = PAR && (ones % 2 == 1);
          good = !m_ferr && !m_perr;
        end
      end
      if (good) begin
        if (!m_valid || hs) begin
          m_dout = word;
          m_valid = 1;
        end else begin
          m_ovr = 1;
        end
      end else if (hs) begin
        m_valid = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("cmp_valid", 32'(dout_valid), 32'(m_valid));
      if (m_valid) check("cmp_dout", 32'(dout), 32'(m_dout));
      check("cmp_ferr", 32'(frame_err), 32'(m_ferr));
      check("cmp_perr", 32'(par_err), 32'(m_perr));
      check("cmp_ovr", 32'(overrun), 32'(m_ovr));
    end
  end

  task automatic send_bit(input logic b);
    si = b;
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [W-1:0] w, input logic stop);
    send_bit(1'b1);
    for (int i = 0; i < W; i++) send_bit(w[i]);
`ifdef SIPO_DEFRAMER_PARITY_EN
    send_bit(^w);
`endif
    send_bit(stop);
  endtask

`ifdef SIPO_DEFRAMER_PARITY_EN
  task automatic send_frame_p(input logic [W-1:0] w, input logic pb);
    send_bit(1'b1);
    for (int i = 0; i < W; i++) send_bit(w[i]);
    send_bit(pb);
    send_bit(1'b0);
  endtask
`endif

  initial begin
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(dout_valid), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);
    rst = 1'b0;
    send_bit(1'b0);
    send_bit(1'b0);

    // 8'hA5 good frame, consumer ready
    send_frame(8'hA5, 1'b0);
    check("a5_dout", 32'(dout), 32'hA5);
    check("a5_valid", 32'(dout_valid), 32'd1);
    check("a5_ferr", 32'(frame_err), 32'd0);
    send_bit(1'b0);
    check("a5_valid_1cyc", 32'(dout_valid), 32'd0);

    // bad stop bit
    send_frame(8'hA5, 1'b1);
    check("bs_ferr", 32'(frame_err), 32'd1);
    check("bs_valid", 32'(dout_valid), 32'd0);
    send_bit(1'b0);
    check("bs_ferr_1cyc", 32'(frame_err), 32'd0);
    check("bs_valid2", 32'(dout_valid), 32'd0);

    // back-to-back with consumer stalled
    dout_ready = 1'b0;
    send_frame(8'h3C, 1'b0);
    check("bb_first", 32'(dout), 32'h3C);
    send_frame(8'hC3, 1'b0);
    check("bb_ovr", 32'(overrun), 32'd1);
    check("bb_hold", 32'(dout), 32'h3C);
    check("bb_valid", 32'(dout_valid), 32'd1);
    send_bit(1'b0);
    check("bb_ovr_1cyc", 32'(overrun), 32'd0);
    dout_ready = 1'b1;
    send_bit(1'b0);
    check("bb_drain", 32'(dout_valid), 32'd0);

    // async reset in the middle of 8'hFF
    send_bit(1'b1);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    si = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("ar_dout", 32'(dout), 32'd0);
    check("ar_valid", 32'(dout_valid), 32'd0);
    check("ar_errs", 32'({frame_err, par_err, overrun}), 32'd0);
    @(negedge clk);
    si = 1'b0;
    rst = 1'b0;
    send_bit(1'b0);
    send_bit(1'b0);
    check("ar_novalid", 32'(dout_valid), 32'd0);
    send_frame(8'h5A, 1'b0);
    check("ar_5a", 32'(dout), 32'h5A);
    check("ar_5a_valid", 32'(dout_valid), 32'd1);
    send_bit(1'b0);

`ifdef SIPO_DEFRAMER_PARITY_EN
    send_frame_p(8'h07, 1'b1);
    check("p_ok_valid", 32'(dout_valid), 32'd1);
    check("p_ok_dout", 32'(dout), 32'h07);
    send_bit(1'b0);
    send_frame_p(8'h07, 1'b0);
    check("p_bad_perr", 32'(par_err), 32'd1);
    check("p_bad_valid", 32'(dout_valid), 32'd0);
    send_bit(1'b0);
`endif

    // mixed traffic against the model
    for (int k = 0; k < 24; k++) begin
      dout_ready = 1'($urandom_range(0, 1));
      send_frame(8'($urandom), 1'($urandom_range(0, 5) == 0));
      repeat ($urandom_range(0, 2)) send_bit(1'b0);
    end
    dout_ready = 1'b1;
    repeat (3) send_bit(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sipo_deframer.md
SIPO_DEFRAMER -- requirements
Module: sipo_deframer

Interface
REQ-001 The block SHALL have one parameter: DATA_W, default 8, payload bits per frame.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port si, input, 1 bit: serial stream, one bit per clk, driven by the upstream siso so output.
REQ-005 The block SHALL have port dout, output, DATA_W bits: last accepted payload.
REQ-006 The block SHALL have port dout_valid, output, 1 bit: dout holds an unconsumed word.
REQ-007 The block SHALL have port dout_ready, input, 1 bit: consumer accepts dout.
REQ-008 The block SHALL have port frame_err, output, 1 bit: one-cycle pulse on a bad stop bit.
REQ-009 The block SHALL have port par_err, output, 1 bit: one-cycle pulse on a parity mismatch.
REQ-010 The block SHALL have port overrun, output, 1 bit: one-cycle pulse when a good word is dropped.

Function
REQ-011 Frame format SHALL be: idle 0, start bit 1, DATA_W data bits LSB first, optional parity bit, then stop bit 0.
REQ-012 The FSM SHALL have states IDLE, DATA, PARITY, STOP; IDLE->DATA on si=1 and stays in IDLE on si=0.
REQ-013 DATA SHALL sample si into bit position cnt (0..DATA_W-1) each cycle; after bit DATA_W-1 it SHALL go to PARITY if enabled, else to STOP.
REQ-014 STOP SHALL always return to IDLE; a stop-bit value of 1 SHALL NOT be taken as a new start bit.
REQ-015 A good frame (stop=0, no parity error) SHALL load dout and set dout_valid on the same edge that samples the stop bit; latency is start edge + DATA_W+1 cycles (+1 with parity).
REQ-016 dout and dout_valid SHALL remain stable until an edge where dout_valid&&dout_ready, after which dout_valid SHALL clear.
REQ-017 If a good word completes on the same edge as a handshake, the new word SHALL load and dout_valid SHALL stay 1.
REQ-018 If a good word completes while dout_valid=1 and dout_ready=0, the new word SHALL be dropped, dout SHALL be retained, and overrun SHALL pulse for 1 cycle.
REQ-019 Stop=1 SHALL pulse frame_err for 1 cycle and discard the word.
REQ-020 Parity error SHALL pulse par_err at the stop-sample edge and discard the word; frame_err and par_err MAY pulse together.

Reset
REQ-021 rst=1 SHALL immediately force state IDLE, cnt 0, shift register 0, dout 0, and dout_valid, frame_err, par_err, overrun all 0.
REQ-022 Reset mid-frame SHALL discard the partial word; the first si=1 after release SHALL be treated as a start bit.

Configuration
REQ-023 With macro SIPO_DEFRAMER_PARITY_EN defined, the PARITY state SHALL exist and check an even-parity bit (XOR of data bits ^ parity bit must equal 0).
REQ-024 Without SIPO_DEFRAMER_PARITY_EN, the PARITY state SHALL be absent, frames SHALL be DATA_W+2 bits, and par_err SHALL be tied to 0.

Structure
REQ-025 Package sipo_deframer_pkg SHALL hold typedef enum state_t {IDLE, DATA, PARITY, STOP}, plus constants START_BIT=1'b1, STOP_BIT=1'b0, and DATA_W_DEF=8.
REQ-026 The one-entry output holding register, with its valid/ready and overrun logic, SHALL be sub-module deframer_obuf; the FSM and shifter stay in sipo_deframer.

Verification (DATA_W=8)
REQ-027 Reset: assert rst mid-simulation -> all outputs 0 within the same cycle, without waiting for a clk edge.
REQ-028 Good frame, no parity, dout_ready=1: si = 1,1,0,1,0,0,1,0,1,0 -> dout=8'hA5, dout_valid high exactly 1 cycle, no error pulses.
REQ-029 Bad stop: frame 8'hA5 sent with stop bit = 1 -> frame_err pulses 1 cycle, dout_valid stays 0, FSM back in IDLE.
REQ-030 Back-to-back 8'h3C then 8'hC3 with dout_ready=0 -> dout=8'h3C held, overrun pulses at the second stop edge; raising dout_ready then clears dout_valid.
REQ-031 Reset during data bit 4 of 8'hFF, then full frame 8'h5A -> no valid for 8'hFF, dout=8'h5A.
REQ-032 With PARITY_EN: 8'h07 with parity bit 1 -> dout_valid, dout=8'h07; 8'h07 with parity bit 0 -> par_err pulse, no dout_valid.
